// File: rtl/seq_det_prog_pkg.sv
// Shared types and defaults for the programmable sequence detector.
// Contents:
//   seq_state_t : detector FSM state (DISABLED / FILLING / ARMED)
//   DEF_MAX_LEN : default maximum pattern length
//   LEN_W       : width of a length field for the default MAX_LEN
//   DEF_PAT     : pattern loaded at reset (LSB = most recent bit)
//   DEF_LEN     : pattern length loaded at reset
package seq_det_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    FILLING  = 2'd1,
    ARMED    = 2'd2
  } seq_state_t;

  localparam int         DEF_MAX_LEN = 8;
  localparam int         LEN_W       = $clog2(DEF_MAX_LEN + 1);
  localparam logic [7:0] DEF_PAT     = 8'b0000_1011;
  localparam int         DEF_LEN     = 4;

endpackage

// File: rtl/seq_det_prog_if.sv
// Bus bundle between the board control logic and the sequence detector.
// Signals:
//   code        : serial data bit
//   load        : latch pattern_in/len_in and restart matching
//   pattern_in  : new pattern, bit 0 = most recent bit
//   len_in      : new pattern length (clamped to MAX_LEN by the detector)
//   overlap     : 1 = overlapping matches, 0 = non-overlapping
//   sample_tick : strobe marking the cycle code is sampled
//   detected    : one-cycle match pulse
//   match_cnt   : saturating match count
// Modports: master drives the controls, slave is the detector.
interface seq_det_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) ();

  logic                           code;
  logic                           load;
  logic [MAX_LEN-1:0]             pattern_in;
  logic [$clog2(MAX_LEN+1)-1:0]   len_in;
  logic                           overlap;
  logic                           sample_tick;
  logic                           detected;
  logic [CNT_W-1:0]               match_cnt;

  modport master (
    output code, load, pattern_in, len_in, overlap,
    input  sample_tick, detected, match_cnt
  );

  modport slave (
    input  code, load, pattern_in, len_in, overlap,
    output sample_tick, detected, match_cnt
  );

endinterface

// File: rtl/seq_det_prog_tick_gen.sv
// Free-running clock divider producing a one-cycle tick every DIV cycles.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   tick_o : high while the counter sits at DIV-1
// The first tick is in cycle DIV-1 after reset release.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) div_cnt_q <= '0;
    else         div_cnt_q <= div_cnt_d;
  end

  // Gated by reset so DIV=1 does not strobe while reset is held.
  assign tick_o = rst_ni & (div_cnt_q == LAST);

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with integrated sample divider.
// One code bit is shifted in per sample tick; detected pulses for one
// cycle when the last len samples equal the loaded pattern.
// Ports:
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : seq_det_prog_if.slave (code/load/pattern_in/len_in/overlap in,
//           sample_tick/detected/match_cnt out)
// Build option: define SEQ_DET_COUNT_EN to build the saturating match
// counter; otherwise match_cnt is tied to zero.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN = DEF_MAX_LEN,
  parameter int                 DIV     = 4,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(DEF_PAT),
  parameter int                 RST_LEN = DEF_LEN,
  parameter int                 CNT_W   = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  seq_det_prog_if.slave bus
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] RST_LEN_C =
    (RST_LEN > MAX_LEN) ? LW'(MAX_LEN) : LW'(RST_LEN);
  localparam seq_state_t RST_STATE = (RST_LEN_C == '0) ? DISABLED : FILLING;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l > LW'(MAX_LEN)) return LW'(MAX_LEN);
    return l;
  endfunction

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LW-1:0] l);
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  function automatic seq_state_t state_of(input logic [LW-1:0] f,
                                          input logic [LW-1:0] l);
    if (l == '0) return DISABLED;
    if (f < l)   return FILLING;
    return ARMED;
  endfunction

  logic tick;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .tick_o (tick)
  );

  seq_state_t         state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] sh_q, sh_d, sh_nx;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      fill_q, fill_d, fill_nx;
  logic               det_q, det_d;
  logic               hit;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RST_STATE;
      pat_q   <= RST_PAT;
      len_q   <= RST_LEN_C;
      sh_q    <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      det_q   <= det_d;
    end
  end

  // Next-state logic; load has priority over a coincident sample tick.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    sh_d    = sh_q;
    fill_d  = fill_q;
    det_d   = 1'b0;
    hit     = 1'b0;
    sh_nx   = {sh_q[MAX_LEN-2:0], bus.code};
    fill_nx = (fill_q < len_q) ? fill_q + LW'(1) : len_q;

    if (bus.load) begin
      pat_d  = bus.pattern_in;
      len_d  = clamp_len(bus.len_in);
      sh_d   = '0;
      fill_d = '0;
    end else if (tick) begin
      sh_d = sh_nx;
      if (state_q != DISABLED) begin
        // Compare only once a full window of len samples is present.
        hit    = (fill_nx == len_q) &&
                 (((sh_nx ^ pat_q) & len_mask(len_q)) == '0);
        fill_d = (hit && !bus.overlap) ? '0 : fill_nx;
        det_d  = hit;
      end
    end

    state_d = state_of(fill_d, len_d);
  end

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (bus.load)  cnt_d = '0;
    else if (hit)  cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // Output logic
  always_comb begin
    bus.sample_tick = tick;
    bus.detected    = det_q;
`ifdef SEQ_DET_COUNT_EN
    bus.match_cnt   = cnt_q;
`else
    bus.match_cnt   = '0;
`endif
  end

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog (DIV=4, MAX_LEN=8, CNT_W=2).
// A window-of-samples reference model predicts sample_tick, detected and
// match_cnt every cycle; directed scenarios are followed by random traffic.
module tb_seq_det_prog;

  localparam int MAX_LEN = 8;
  localparam int DIV     = 4;
  localparam int CNT_W   = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam logic [7:0] RPAT = 8'b0000_1011;
  localparam int RLEN    = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;

  seq_det_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_det_prog #(
    .MAX_LEN (MAX_LEN),
    .DIV     (DIV),
    .RST_PAT (RPAT),
    .RST_LEN (RLEN),
    .CNT_W   (CNT_W)
  ) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model state
  int         mcyc;
  bit         hist[$];
  int         mlen;
  logic [7:0] mpat;
  bit         mdet;
  int         mcnt;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_c(input int n);
`ifdef SEQ_DET_COUNT_EN
    return (n > CMAX) ? CMAX : n;
`else
    return 0;
`endif
  endfunction

  function automatic bit win_match();
    for (int i = 0; i < mlen; i++)
      if (hist[mlen-1-i] != mpat[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    mcyc = 0;
    hist.delete();
    mlen = RLEN;
    mpat = RPAT;
    mdet = 1'b0;
    mcnt = 0;
  endfunction

  // Check this cycle's outputs, advance the model across the next edge.
  task automatic cycle();
    bit t;
    t = ((mcyc % DIV) == DIV - 1);
    check("sample_tick", {31'd0, bus.sample_tick}, {31'd0, t});
    check("detected", {31'd0, bus.detected}, {31'd0, mdet});
    check("match_cnt", 32'(bus.match_cnt), 32'(exp_c(mcnt)));
    if (bus.detected === 1'b1) pulses++;
    mdet = 1'b0;
    if (bus.load) begin
      mpat = bus.pattern_in;
      mlen = (int'(bus.len_in) > MAX_LEN) ? MAX_LEN : int'(bus.len_in);
      hist.delete();
      mcnt = 0;
    end else if (t && mlen > 0) begin
      hist.push_back(bus.code);
      if (hist.size() > mlen) void'(hist.pop_front());
      if (hist.size() == mlen && win_match()) begin
        mdet = 1'b1;
        mcnt++;
        if (!bus.overlap) hist.delete();
      end
    end
    mcyc++;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_bit(input bit b);
    bit t;
    bus.code = b;
    for (int i = 0; i < DIV; i++) begin
      t = ((mcyc % DIV) == DIV - 1);
      cycle();
      if (t) break;
    end
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    logic [15:0] tmp;
    tmp = v;
    for (int i = n - 1; i >= 0; i--) send_bit(tmp[i]);
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l);
    bus.load       = 1'b1;
    bus.pattern_in = p;
    bus.len_in     = l;
    cycle();
    bus.load = 1'b0;
  endtask

  task automatic do_reset();
    bus.load = 1'b0;
    RST_N = 1'b0;
    #1;
    check("rst_tick", {31'd0, bus.sample_tick}, 32'd0);
    check("rst_det", {31'd0, bus.detected}, 32'd0);
    check("rst_cnt", 32'(bus.match_cnt), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.code = 1'b0;
    bus.load = 1'b0;
    bus.pattern_in = '0;
    bus.len_in = '0;
    bus.overlap = 1'b1;
    @(negedge CLK);

    // Reset and divider cadence
    do_reset();
    idle(12);

    // Overlapping matches: 1,0,1,1,0,1,1
    pulses = 0;
    bus.overlap = 1'b1;
    send_bits(16'b1011011, 7);
    idle(2);
    check("ovl1_pulses", 32'(pulses), 32'd2);
    check("ovl1_cnt", 32'(bus.match_cnt), 32'(exp_c(2)));

    // Non-overlapping matches on the same stream
    do_reset();
    pulses = 0;
    bus.overlap = 1'b0;
    send_bits(16'b1011011, 7);
    idle(2);
    check("ovl0_pulses", 32'(pulses), 32'd1);
    check("ovl0_cnt", 32'(bus.match_cnt), 32'(exp_c(1)));

    // Runtime reload: pattern 110, len 3
    do_load(8'b0000_0110, 4'd3);
    check("load_cnt_clr", 32'(bus.match_cnt), 32'd0);
    pulses = 0;
    send_bits(16'b110110, 6);
    idle(2);
    check("reload_pulses", 32'(pulses), 32'd2);

    // Load coincident with a tick drops that sample
    for (int i = 0; i < DIV; i++)
      if ((mcyc % DIV) != DIV - 1) cycle();
    check("align_tick", {31'd0, bus.sample_tick}, 32'd1);
    bus.code = 1'b1;
    do_load(8'b0000_0110, 4'd3);
    pulses = 0;
    send_bits(16'b10, 2);
    idle(2);
    check("coinc_drop_pulses", 32'(pulses), 32'd0);
    send_bits(16'b110, 3);
    idle(2);
    check("coinc_after_pulses", 32'(pulses), 32'd1);

    // len 0: disabled, never matches
    do_load(8'h00, 4'd0);
    pulses = 0;
    send_bits(16'h0000, 10);
    idle(2);
    check("len0_pulses", 32'(pulses), 32'd0);

    // len 15 clamps to 8
    bus.overlap = 1'b0;
    do_load(8'b1010_0111, 4'd15);
    pulses = 0;
    send_bits(16'b1010011, 7);
    idle(2);
    check("len15_early", 32'(pulses), 32'd0);
    send_bit(1'b1);
    idle(2);
    check("len15_pulses", 32'(pulses), 32'd1);

    // Counter saturation: pattern 11, len 2, overlapping
    bus.overlap = 1'b1;
    do_load(8'b0000_0011, 4'd2);
    pulses = 0;
    send_bits(16'h7F, 7);
    idle(2);
    check("sat_pulses", 32'(pulses), 32'd6);
    check("sat_cnt", 32'(bus.match_cnt), 32'(exp_c(6)));

    // Mid-stream reset after 3 matching bits
    do_reset();
    bus.overlap = 1'b0;
    send_bits(16'b101, 3);
    do_reset();
    pulses = 0;
    send_bit(1'b1);
    idle(2);
    check("midrst_pulses", 32'(pulses), 32'd0);
    send_bits(16'b1011, 4);
    idle(2);
    check("midrst_pat", 32'(pulses), 32'd1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bus.code = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) bus.overlap = ~bus.overlap;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 39) == 0) begin
        bus.load = 1'b1;
        bus.pattern_in = 8'($urandom);
        bus.len_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(1, 3));
        cycle();
        bus.load = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
